fp_mult_seq: RTL and testbench

// - Iterative IEEE-754 multiplier controller; sequences exponent add, shift-add mantissa multiply, normalise, round.
// - Accepts one operand pair per valid/ready handshake; returns packed result plus exception flags.
// - Sits between the FP register file/issue logic and writeback; one operation in flight.

---
 rtl/fp_mult_pkg.sv | 34 +++
 rtl/fp_mult_seq_mant_shift_mult.sv | 61 ++++++
 rtl/fp_mult_seq.sv | 230 +++++++++++++++++++++++
 tb/tb_fp_mult_seq.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the sequential IEEE-754 multiplier.
package fp_mult_pkg;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    MULT,
    NORM,
    ROUND,
    DONE
  } state_t;

  // Field geometry for binary32 and binary64.
  localparam int SP_WIDTH = 32;
  localparam int SP_EXP_W = 8;
  localparam int SP_MAN_W = 23;
  localparam int SP_BIAS  = 127;

  localparam int DP_WIDTH = 64;
  localparam int DP_EXP_W = 11;
  localparam int DP_MAN_W = 52;
  localparam int DP_BIAS  = 1023;

  // Canonical quiet NaN: sign 0, exponent all ones, fraction MSB set.
  localparam logic [31:0] SP_QNAN = 32'h7FC0_0000;
  localparam logic [63:0] DP_QNAN = 64'h7FF8_0000_0000_0000;

  // Bit positions inside the 4-bit flags vector.
  localparam int FLAG_INVALID   = 3;
  localparam int FLAG_OVERFLOW  = 2;
  localparam int FLAG_UNDERFLOW = 1;
  localparam int FLAG_INEXACT   = 0;

endpackage

// File: rtl/fp_mult_seq_mant_shift_mult.sv
// Iterative unsigned N x N shift-add multiplier, one multiplier bit per cycle,
// LSB first. Loaded by start; busy for N cycles; done flags the final iteration.
module mant_shift_mult
  import fp_mult_pkg::*;
#(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  logic [N-1:0]   mcand;
  logic [2*N-1:0] acc;
  logic [CW-1:0]  cnt;
  logic [N:0]     sum;

  // Upper half accumulates the multiplicand whenever the current multiplier bit is set.
  always_comb begin
    sum = {1'b0, acc[2*N-1:N]} + {1'b0, (acc[0] ? mcand : {N{1'b0}})};
  end

  // Low half starts as the multiplier and is consumed as the product shifts in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mcand <= '0;
      acc   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
    end else if (start) begin
      mcand <= a;
      acc   <= {{N{1'b0}}, b};
      cnt   <= '0;
      busy  <= 1'b1;
    end else if (busy) begin
      acc <= {sum, acc[N-1:1]};
      if (cnt == LAST) begin
        cnt  <= '0;
        busy <= 1'b0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  // Final iteration index reached; the owner qualifies this with busy.
  always_comb begin
    done = (cnt == LAST);
  end

  assign product = acc;

endmodule

// File: rtl/fp_mult_seq.sv
// Sequential IEEE-754 multiplier: unpack, iterative mantissa multiply,
// normalise, round-to-nearest-even, with special-case override. Fixed latency.
module fp_mult_seq
  import fp_mult_pkg::*;
#(
  parameter int IS_DOUBLE  = 0,
  parameter int WIDTH      = (IS_DOUBLE != 0) ? DP_WIDTH : SP_WIDTH,
  parameter int EXPONENT_W = (IS_DOUBLE != 0) ? DP_EXP_W : SP_EXP_W,
  parameter int MANTISSA_W = (IS_DOUBLE != 0) ? DP_MAN_W : SP_MAN_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic [3:0]       flags
);

  localparam int N  = MANTISSA_W + 1;
  localparam int EE = EXPONENT_W + 2;
  localparam int BIAS = (IS_DOUBLE != 0) ? DP_BIAS : SP_BIAS;
  localparam logic signed [EE-1:0] BIAS_S  = EE'(BIAS);
  localparam logic signed [EE-1:0] EXP_MAX = EE'((1 << EXPONENT_W) - 1);
  localparam logic [63:0] QNAN_FULL = (IS_DOUBLE != 0) ? DP_QNAN : {32'h0, SP_QNAN};
  localparam logic [WIDTH-1:0] QNAN = QNAN_FULL[WIDTH-1:0];

  state_t state, state_next;

  logic [WIDTH-1:0] a_q, b_q;
  logic             mult_start, mult_busy, mult_done;
  logic [2*N-1:0]   product;

  // Unpacked operand fields.
  logic                  s1, s2;
  logic [EXPONENT_W-1:0] e1, e2;
  logic [MANTISSA_W-1:0] f1, f2;
  logic                  z1, z2, inf1, inf2, nan1, nan2;
  logic [N-1:0]          m1, m2;
  logic signed [EE-1:0]  e_sum;

  // Special-case decode and latched copy.
  logic             spec_hit, spec_hit_q;
  logic [WIDTH-1:0] spec_res, spec_res_q;
  logic [3:0]       spec_flags, spec_flags_q;

  // Datapath state between stages.
  logic                  sign_q;
  logic signed [EE-1:0]  exp_q;
  logic [MANTISSA_W-1:0] frac_q;
  logic                  guard_q, sticky_q;

  logic signed [EE-1:0]  norm_exp;
  logic [MANTISSA_W-1:0] norm_frac;
  logic                  norm_guard, norm_sticky;

  logic                  round_up;
  logic [MANTISSA_W:0]   rsum;
  logic signed [EE-1:0]  rexp;
  logic [WIDTH-1:0]      round_res;
  logic [3:0]            round_flags;

  assign {s1, e1, f1} = a_q;
  assign {s2, e2, f2} = b_q;

  // Field classification; zero exponents (zeros and denormals) flush to zero.
  always_comb begin
    z1    = (e1 == '0);
    z2    = (e2 == '0);
    inf1  = (e1 == '1) && (f1 == '0);
    inf2  = (e2 == '1) && (f2 == '0);
    nan1  = (e1 == '1) && (f1 != '0);
    nan2  = (e2 == '1) && (f2 != '0);
    m1    = z1 ? '0 : {1'b1, f1};
    m2    = z2 ? '0 : {1'b1, f2};
    e_sum = $signed({2'b00, e1}) + $signed({2'b00, e2}) - BIAS_S;
  end

  // Special operands bypass the datapath result entirely.
  always_comb begin
    spec_hit   = 1'b0;
    spec_res   = '0;
    spec_flags = '0;
    if (nan1 || nan2 || (inf1 && z2) || (inf2 && z1)) begin
      spec_hit                 = 1'b1;
      spec_res                 = QNAN;
      spec_flags[FLAG_INVALID] = 1'b1;
    end else if (inf1 || inf2) begin
      spec_hit = 1'b1;
      spec_res = {s1 ^ s2, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
    end else if (z1 || z2) begin
      spec_hit = 1'b1;
      spec_res = {s1 ^ s2, {(WIDTH-1){1'b0}}};
    end
  end

  mant_shift_mult #(
    .N(N)
  ) u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (m1),
    .b       (m2),
    .busy    (mult_busy),
    .done    (mult_done),
    .product (product)
  );

  // Normalise: product lies in [1,4); a set MSB means one extra exponent step.
  always_comb begin
    if (product[2*N-1]) begin
      norm_exp    = exp_q + EE'(1);
      norm_frac   = product[2*N-2 -: MANTISSA_W];
      norm_guard  = product[N-1];
      norm_sticky = |product[N-2:0];
    end else begin
      norm_exp    = exp_q;
      norm_frac   = product[2*N-3 -: MANTISSA_W];
      norm_guard  = product[N-2];
      norm_sticky = |product[N-3:0];
    end
  end

  // Round to nearest even, then range-check the exponent and apply overrides.
  always_comb begin
    round_up    = guard_q & (sticky_q | frac_q[0]);
    rsum        = {1'b0, frac_q} + {{MANTISSA_W{1'b0}}, round_up};
    rexp        = rsum[MANTISSA_W] ? exp_q + EE'(1) : exp_q;
    round_res   = {sign_q, rexp[EXPONENT_W-1:0], rsum[MANTISSA_W-1:0]};
    round_flags = '0;
    round_flags[FLAG_INEXACT] = guard_q | sticky_q;
    if (!rexp[EE-1] && (rexp >= EXP_MAX)) begin
      round_res                  = {sign_q, {EXPONENT_W{1'b1}}, {MANTISSA_W{1'b0}}};
      round_flags                = '0;
      round_flags[FLAG_OVERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]  = 1'b1;
    end else if (rexp[EE-1] || (rexp == '0)) begin
      round_res                   = {sign_q, {(WIDTH-1){1'b0}}};
      round_flags                 = '0;
      round_flags[FLAG_UNDERFLOW] = 1'b1;
      round_flags[FLAG_INEXACT]   = 1'b1;
    end
    if (spec_hit_q) begin
      round_res   = spec_res_q;
      round_flags = spec_flags_q;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and handshake/control decode.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    mult_start = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = UNPACK;
      end
      UNPACK: begin
        mult_start = 1'b1;
        state_next = MULT;
      end
      MULT:    if (mult_busy && mult_done) state_next = NORM;
      NORM:    state_next = ROUND;
      ROUND:   state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand capture and per-stage datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q          <= '0;
      b_q          <= '0;
      sign_q       <= 1'b0;
      exp_q        <= '0;
      frac_q       <= '0;
      guard_q      <= 1'b0;
      sticky_q     <= 1'b0;
      spec_hit_q   <= 1'b0;
      spec_res_q   <= '0;
      spec_flags_q <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        a_q <= op1;
        b_q <= op2;
      end
      if (state == UNPACK) begin
        sign_q       <= s1 ^ s2;
        exp_q        <= e_sum;
        spec_hit_q   <= spec_hit;
        spec_res_q   <= spec_res;
        spec_flags_q <= spec_flags;
      end
      if (state == NORM) begin
        exp_q    <= norm_exp;
        frac_q   <= norm_frac;
        guard_q  <= norm_guard;
        sticky_q <= norm_sticky;
      end
    end
  end

  // Output registers: loaded on entry to DONE, held until the consumer takes them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      res       <= '0;
      flags     <= '0;
    end else begin
      out_valid <= (state_next == DONE);
      if (state == ROUND) begin
        res   <= round_res;
        flags <= round_flags;
      end
    end
  end

endmodule

// File: tb/tb_fp_mult_seq.sv
// Self-checking bench for fp_mult_seq (binary32): directed cases, backpressure,
// reset during operation, and randomized operands against an arithmetic model.
module tb_fp_mult_seq;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] op1, op2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic [3:0]  flags;

  int checks = 0;
  int errors = 0;

  fp_mult_seq #(
    .IS_DOUBLE(0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op1       (op1),
    .op2       (op2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .flags     (flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: exact integer product of significands, rounded by remainder comparison.
  function automatic void ref_mul(input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [3:0] f);
    logic            s;
    int              ea, eb, e, sh;
    logic [22:0]     fa, fb;
    longint unsigned p, q, rem, half;
    bit              za, zb, ia, ib, na, nb, up;
    s  = a[31] ^ b[31];
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    fa = a[22:0];
    fb = b[22:0];
    za = (ea == 0);
    zb = (eb == 0);
    ia = (ea == 255) && (fa == 0);
    ib = (eb == 255) && (fb == 0);
    na = (ea == 255) && (fa != 0);
    nb = (eb == 255) && (fb != 0);
    f  = 4'b0000;
    if (na || nb || (ia && zb) || (ib && za)) begin
      r = 32'h7FC0_0000;
      f = 4'b1000;
    end else if (ia || ib) begin
      r = {s, 8'hFF, 23'h0};
    end else if (za || zb) begin
      r = {s, 31'h0};
    end else begin
      p = ((64'd1 << 23) | 64'(fa)) * ((64'd1 << 23) | 64'(fb));
      e = ea + eb - 127;
      if (p >= (64'd1 << 47)) begin
        sh = 24;
        e  = e + 1;
      end else begin
        sh = 23;
      end
      q    = p >> sh;
      rem  = p & ((64'd1 << sh) - 64'd1);
      half = 64'd1 << (sh - 1);
      up   = (rem > half) || ((rem == half) && q[0]);
      q    = q + 64'(up);
      if (q == (64'd1 << 24)) begin
        q = 64'd1 << 23;
        e = e + 1;
      end
      if (e >= 255) begin
        r = {s, 8'hFF, 23'h0};
        f = 4'b0101;
      end else if (e <= 0) begin
        r = {s, 31'h0};
        f = 4'b0011;
      end else begin
        r = {s, 8'(e), q[22:0]};
        f = {3'b000, rem != 0};
      end
    end
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v = $urandom;
    case ($urandom_range(0, 9))
      0: v[30:23] = 8'h00;
      1: v[30:23] = 8'hFF;
      2: begin v[30:23] = 8'hFF; v[22:0] = 23'h0; end
      3: v[30:23] = 8'($urandom_range(1, 40));
      4: v[30:23] = 8'($urandom_range(215, 254));
      default: v[30:23] = 8'($urandom_range(90, 165));
    endcase
    return v;
  endfunction

  task automatic start_op(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    check("accept_in_ready", 64'(in_ready), 64'd1);
    op1      = a;
    op2      = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op1      = $urandom;
    op2      = $urandom;
  endtask

  // Bounded wait for out_valid; optionally pulses in_valid while the op is in flight.
  task automatic wait_done(input logic [31:0] exp_r, input logic [3:0] exp_f, input bit pulse);
    int lat;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (pulse && lat >= 3 && lat <= 8) begin
        in_valid = 1'b1;
        op1      = $urandom;
        op2      = $urandom;
      end else begin
        in_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      lat++;
    end
    in_valid = 1'b0;
    check("latency", 64'(lat), 64'd27);
    check("res", 64'(res), 64'(exp_r));
    check("flags", 64'(flags), 64'(exp_f));
  endtask

  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_r, input logic [3:0] exp_f,
                        input int hold, input bit pulse);
    start_op(a, b);
    wait_done(exp_r, exp_f, pulse);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check("hold_out_valid", 64'(out_valid), 64'd1);
      check("hold_in_ready", 64'(in_ready), 64'd0);
      check("hold_res", 64'(res), 64'(exp_r));
      check("hold_flags", 64'(flags), 64'(exp_f));
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("take_out_valid", 64'(out_valid), 64'd0);
    check("take_in_ready", 64'(in_ready), 64'd1);
  endtask

  initial begin
    logic [31:0] a, b, r;
    logic [3:0]  f;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op1       = '0;
    op2       = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_res", 64'(res), 64'd0);
    check("reset_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_in_ready", 64'(in_ready), 64'd1);

    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 0, 1'b0);
    run_op(32'hC000_0000, 32'h3FC0_0000, 32'hC040_0000, 4'b0000, 1, 1'b0);
    run_op(32'h3F80_0001, 32'h3F80_0001, 32'h3F80_0002, 4'b0001, 0, 1'b0);
    run_op(32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 4'b0101, 0, 1'b0);
    run_op(32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 4'b0011, 0, 1'b0);
    run_op(32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 4'b1000, 0, 1'b0);
    run_op(32'hFF80_0000, 32'h4000_0000, 32'hFF80_0000, 4'b0000, 0, 1'b0);
    run_op(32'h8000_0000, 32'h4000_0000, 32'h8000_0000, 4'b0000, 0, 1'b0);

    // Backpressure with in_valid noise while the operation is in flight.
    run_op(32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4'b0000, 10, 1'b1);

    // Reset mid-multiply, then a clean operation.
    start_op(32'h3FC0_0000, 32'h3FC0_0000);
    repeat (10) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid2", 64'(out_valid), 64'd0);
    run_op(32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 4'b0000, 0, 1'b0);

    // Asynchronous reset while a result is being held.
    start_op(32'h3F80_0001, 32'h3F80_0001);
    wait_done(32'h3F80_0002, 4'b0001, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("donerst_out_valid", 64'(out_valid), 64'd0);
    check("donerst_res", 64'(res), 64'd0);
    check("donerst_flags", 64'(flags), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("donerst_in_ready", 64'(in_ready), 64'd1);

    // Randomized operands against the reference model.
    for (int i = 0; i < 60; i++) begin
      a = rand_op();
      b = rand_op();
      ref_mul(a, b, r, f);
      run_op(a, b, r, f, int'($urandom_range(0, 2)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
